// File: rtl/nor3_sweep_ctrl.sv
// Exhaustive sweep sequencer and checker for an N_IN-input combinational gate.
// Each input vector is held for HOLD_CYCLES cycles, and the gate output is
// sampled on the last cycle of that window and compared with EXPECT.
module nor3_sweep_ctrl #(
  parameter int unsigned              N_IN        = 3,
  parameter int unsigned              HOLD_CYCLES = 10,
  parameter logic [(2**N_IN)-1:0]     EXPECT      = 8'b0000_0001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      vec,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [(2**N_IN)-1:0] result,
  output logic [N_IN:0]        err_count,
  output logic                 pass
);

  localparam int unsigned    NV        = 2 ** N_IN;
  localparam int unsigned    ERR_W     = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);
  localparam logic [7:0]     HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state;
  logic [7:0]        hold_cnt;
  logic [N_IN-1:0]   idx;
  logic              mismatch_c;
  logic [ERR_W-1:0]  err_next_c;

  // Mismatch of the current sample against the expected truth table
  always_comb begin
    mismatch_c = (dut_out != EXPECT[idx]);
    err_next_c = err_count + ERR_W'(mismatch_c);
  end

  // Sweep FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      idx       <= '0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= DRIVE;
            idx       <= '0;
            vec       <= '0;
            hold_cnt  <= '0;
            result    <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end

        DRIVE: begin
          if (abort) begin
            // abort wins over a coincident sample; partial results are kept
            state <= IDLE;
            busy  <= 1'b0;
            vec   <= '0;
            pass  <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            result[idx] <= dut_out;
            err_count   <= err_next_c;
            if (idx == LAST_IDX) begin
              state <= FINISH;
              done  <= 1'b1;
              pass  <= (err_next_c == '0);
            end else begin
              idx      <= idx + 1'b1;
              vec      <= idx + 1'b1;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          vec   <= '0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          vec   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor3_sweep_ctrl.sv
// Scoreboard bench for nor3_sweep_ctrl: stimulus pushes the expected sweep
// outcome, and per-instance monitors pop and compare on every done pulse.
module tb_nor3_sweep_ctrl;

  typedef struct {
    logic [7:0] res;
    logic [3:0] err;
    logic       pas;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, abort0, start1, abort1;
  logic [2:0] vec0, vec1;
  logic       dut0, dut1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] result0, result1;
  logic [3:0] err0, err1;

  int   mode = 0;  // 0: NOR, 1: stuck-at-0, 2: OR
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   done0_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Gate models driven by the sweepers
  always_comb begin
    case (mode)
      0:       dut0 = ~|vec0;
      1:       dut0 = 1'b0;
      default: dut0 = |vec0;
    endcase
  end
  assign dut1 = ~|vec1;

  nor3_sweep_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .vec(vec0),
    .dut_out(dut0), .busy(busy0), .done(done0), .result(result0),
    .err_count(err0), .pass(pass0)
  );

  nor3_sweep_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .vec(vec1),
    .dut_out(dut1), .busy(busy1), .done(done1), .result(result1),
    .err_count(err1), .pass(pass1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pulse start0 for one edge; optionally push the expected outcome
  task automatic issue0(input bit push, input logic [7:0] r, input logic [3:0] e,
                        input logic p, output int k);
    exp_t x;
    start0 = 1'b1;
    k = cyc + 1;
    if (push) begin
      x.res = r; x.err = e; x.pas = p; x.cyc = k + 80;
      q0.push_back(x);
    end
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // Monitor for instance 0
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done0 === 1'b1) begin
      done0_cnt++;
      if (q0.size() == 0) begin
        total++;
        $display("FAIL unexpected_done0: done seen at cycle %0d, expected none", cyc);
      end else begin
        e = q0.pop_front();
        chk("done0_cycle", cyc, e.cyc);
        chk("result0", result0, e.res);
        chk("err0", err0, e.err);
        chk("pass0", pass0, e.pas);
        chk("busy0_in_finish", busy0, 1);
      end
    end
  end

  // Monitor for instance 1
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL unexpected_done1: done seen at cycle %0d, expected none", cyc);
      end else begin
        e = q1.pop_front();
        chk("done1_cycle", cyc, e.cyc);
        chk("result1", result1, e.res);
        chk("err1", err1, e.err);
        chk("pass1", pass1, e.pas);
      end
    end
  end

  initial begin
    int   k, k2, dc;
    exp_t x;
    rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vec", vec0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_result", result0, 0);
    chk("rst_err", err0, 0);
    chk("rst_pass", pass0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct NOR: vector walk and final outcome
    mode = 0;
    issue0(1'b1, 8'h01, 4'd0, 1'b1, k);
    for (int i = 0; i < 8; i++) begin
      wait_until(k + 10 * i + 5);
      chk("t1_vec", vec0, i);
      chk("t1_busy", busy0, 1);
    end
    wait_until(k + 81);
    chk("t1_done_seen", q0.size(), 0);
    chk("t1_idle_busy", busy0, 0);
    chk("t1_idle_vec", vec0, 0);

    // Stuck-at-0 gate
    mode = 1;
    issue0(1'b1, 8'h00, 4'd1, 1'b0, k);
    wait_until(k + 81);
    chk("t2_done_seen", q0.size(), 0);

    // OR gate
    mode = 2;
    issue0(1'b1, 8'hFE, 4'd8, 1'b0, k);
    wait_until(k + 81);
    chk("t3_done_seen", q0.size(), 0);

    // start in DRIVE and FINISH ignored; start right after done accepted
    mode = 0;
    issue0(1'b1, 8'h01, 4'd0, 1'b1, k);
    wait_until(k + 35);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_until(k + 55);
    chk("t4_vec_unchanged", vec0, 5);
    wait_until(k + 80);
    chk("t4_done_now", done0, 1);
    start0 = 1'b1;
    @(negedge clk);
    chk("t4_finish_start_ignored", busy0, 0);
    k2 = cyc + 1;
    x.res = 8'h01; x.err = 4'd0; x.pas = 1'b1; x.cyc = k2 + 80;
    q0.push_back(x);
    @(negedge clk);
    start0 = 1'b0;
    chk("t4_restart_busy", busy0, 1);
    chk("t4_restart_vec", vec0, 0);
    wait_until(k2 + 81);
    chk("t4_done_seen", q0.size(), 0);

    // abort in the 5th cycle of vector 3
    dc = done0_cnt;
    issue0(1'b0, 8'h00, 4'd0, 1'b0, k);
    wait_until(k + 34);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("t5_busy", busy0, 0);
    chk("t5_vec", vec0, 0);
    chk("t5_done", done0, 0);
    chk("t5_result", result0, 8'h01);
    chk("t5_err", err0, 0);
    chk("t5_pass", pass0, 0);
    wait_until(k + 100);
    chk("t5_no_done", done0_cnt, dc);

    // reset pulse during vector 5
    dc = done0_cnt;
    issue0(1'b0, 8'h00, 4'd0, 1'b0, k);
    wait_until(k + 53);
    chk("t6_vec_before_rst", vec0, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_vec", vec0, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_done", done0, 0);
    chk("t6_result", result0, 0);
    chk("t6_err", err0, 0);
    chk("t6_pass", pass0, 0);
    wait_until(k + 100);
    chk("t6_no_done", done0_cnt, dc);

    // HOLD_CYCLES=1 instance
    start1 = 1'b1;
    k = cyc + 1;
    x.res = 8'h01; x.err = 4'd0; x.pas = 1'b1; x.cyc = k + 8;
    q1.push_back(x);
    @(negedge clk);
    start1 = 1'b0;
    chk("t7_vec0", vec1, 0);
    wait_until(k + 4);
    chk("t7_vec4", vec1, 4);
    wait_until(k + 12);
    chk("t7_done_seen", q1.size(), 0);
    chk("t7_idle_busy", busy1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
